// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: per-channel 2-flop synchronizer, debounce FSM and
// registered level / one-cycle rise / fall pulse outputs.
module btn_pulse_gen #(
  parameter int unsigned N_CH            = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // A single stable sample is enough: skip the arm states entirely.
  localparam bit          SINGLE = (DEBOUNCE_CYCLES == 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal parameterisations at elaboration.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_pulse_gen: DEBOUNCE_CYCLES must be >= 1");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("btn_pulse_gen: N_CH must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    ARM_HI  = 2'd1,
    IDLE_HI = 2'd2,
    ARM_LO  = 2'd3
  } state_t;

  logic [N_CH-1:0] r_s1;
  logic [N_CH-1:0] r_s;

  // Two-flop synchronizer; only r_s is used downstream.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1 <= '0;
      r_s  <= '0;
    end else begin
      r_s1 <= btn_in;
      r_s  <= r_s1;
    end
  end

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             w_level_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_s;

    assign w_s = r_s[g];

    // State, counter and registered outputs; reset aborts any pending acceptance.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_state <= IDLE_LO;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_level <= w_level_nxt;
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
      end
    end

    // Next-state: arm on a level change, confirm after DEBOUNCE_CYCLES samples.
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        IDLE_LO: if (w_s)  w_state_nxt = SINGLE ? IDLE_HI : ARM_HI;
        ARM_HI: begin
          if (!w_s)                 w_state_nxt = IDLE_LO;
          else if (r_cnt == CNT_LAST) w_state_nxt = IDLE_HI;
        end
        IDLE_HI: if (!w_s) w_state_nxt = SINGLE ? IDLE_LO : ARM_LO;
        ARM_LO: begin
          if (w_s)                  w_state_nxt = IDLE_HI;
          else if (r_cnt == CNT_LAST) w_state_nxt = IDLE_LO;
        end
        default: w_state_nxt = IDLE_LO;
      endcase
    end

    // Next counter / level / pulse values; counter is cleared on abort or accept.
    always_comb begin
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
        IDLE_LO: begin
          if (w_s) begin
            if (SINGLE) begin
              w_cnt_nxt   = '0;
              w_level_nxt = 1'b1;
              w_rise_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = CNT_W'(1);
            end
          end
        end
        ARM_HI: begin
          if (!w_s) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        IDLE_HI: begin
          if (!w_s) begin
            if (SINGLE) begin
              w_cnt_nxt   = '0;
              w_level_nxt = 1'b0;
              w_fall_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = CNT_W'(1);
            end
          end
        end
        ARM_LO: begin
          if (w_s) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end
      endcase
    end

    assign level_out[g]  = r_level;
    assign rise_pulse[g] = r_rise;
    assign fall_pulse[g] = r_fall;
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen (N_CH=2, DEBOUNCE_CYCLES=4).
module tb_btn_pulse_gen;

  localparam int unsigned N_CH = 2;
  localparam int unsigned DEB  = 4;
  // Negedge index (counted from the cycle inputs change) at which a held
  // change is accepted: first sample edge + 1 + DEB.
  localparam int ACC = DEB + 2;
  localparam int NEVER = 1000;

  logic            clk;
  logic            rstn;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] level_out;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;

  int checks = 0;
  int errors = 0;

  btn_pulse_gen #(.N_CH(N_CH), .DEBOUNCE_CYCLES(DEB)) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .btn_in     (btn_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply b, run n cycles; an event (rise_k/fall_k pulse, level change) is
  // expected at negedge k, nothing else happens.
  task automatic run(input string tag, input logic [1:0] b, input int n, input int k,
                     input logic [1:0] rise_k, input logic [1:0] fall_k,
                     input logic [1:0] lvl_pre, input logic [1:0] lvl_post);
    btn_in = b;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk({tag, ".rise"},  32'(rise_pulse), 32'((i == k) ? rise_k : 2'b00));
      chk({tag, ".fall"},  32'(fall_pulse), 32'((i == k) ? fall_k : 2'b00));
      chk({tag, ".level"}, 32'(level_out),  32'((i >= k) ? lvl_post : lvl_pre));
      chk({tag, ".excl"},  32'(rise_pulse & fall_pulse), 32'(0));
    end
  endtask

  initial begin
    rstn   = 1'b0;
    btn_in = 2'b11;
    // Reset held with inputs high: everything stays 0.
    run("rst_hold", 2'b11, 3, NEVER, 2'b00, 2'b00, 2'b00, 2'b00);
    rstn = 1'b1;
    // Held-high inputs count as a new press after release.
    run("rst_press", 2'b11, ACC + 2, ACC, 2'b11, 2'b00, 2'b00, 2'b11);
    // Release both.
    run("rel_both", 2'b00, ACC + 2, ACC, 2'b00, 2'b11, 2'b11, 2'b00);
    // Clean press on ch0.
    run("press0", 2'b01, ACC + 2, ACC, 2'b01, 2'b00, 2'b00, 2'b01);
    // ch1 glitch of 3 cycles is rejected.
    run("glitch1_hi", 2'b11, 3, NEVER, 2'b00, 2'b00, 2'b01, 2'b01);
    run("glitch1_lo", 2'b01, 8, NEVER, 2'b00, 2'b00, 2'b01, 2'b01);
    // Then a stable press on ch1 is accepted once.
    run("press1", 2'b11, ACC + 3, ACC, 2'b10, 2'b00, 2'b01, 2'b11);
    // ch0 release bounce: low 2, high 1, low held.
    run("bounce_lo", 2'b10, 2, NEVER, 2'b00, 2'b00, 2'b11, 2'b11);
    run("bounce_hi", 2'b11, 1, NEVER, 2'b00, 2'b00, 2'b11, 2'b11);
    run("bounce_fin", 2'b10, ACC + 3, ACC, 2'b00, 2'b01, 2'b11, 2'b10);
    // Release ch1, then press both together.
    run("rel1", 2'b00, ACC + 2, ACC, 2'b00, 2'b10, 2'b10, 2'b00);
    run("simul", 2'b11, ACC + 2, ACC, 2'b11, 2'b00, 2'b00, 2'b11);
    run("rel_both2", 2'b00, ACC + 2, ACC, 2'b00, 2'b11, 2'b11, 2'b00);
    // Press ch0 until its counter reaches 2, then reset mid-arm.
    run("arm0", 2'b01, 4, NEVER, 2'b00, 2'b00, 2'b00, 2'b00);
    rstn = 1'b0;
    run("rst_mid", 2'b01, 2, NEVER, 2'b00, 2'b00, 2'b00, 2'b00);
    rstn = 1'b1;
    // Acceptance restarts from a full count.
    run("rst_restart", 2'b01, ACC + 2, ACC, 2'b01, 2'b00, 2'b00, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
- Input-conditioning stage that drives the start/stop request inputs of the run-control FSM.
- Each of N_CH raw, asynchronous button/strobe lines is synchronized, debounced, and converted to a clean level and one-cycle rise/fall pulses.
- rise_pulse[0] feeds the FSM start input (in0); rise_pulse[1] feeds its stop input (in1).

Parameters:
- N_CH, 2, number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples required to accept a level change (>=1; 0 is illegal, elaboration error).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width (derived, not overridden).

Ports:
- clk  input  1  clock.
- rstn  input  1  reset: synchronous, active-low.
- btn_in  input  N_CH  raw asynchronous inputs, active-high.
- level_out  output  N_CH  debounced level per channel.
- rise_pulse  output  N_CH  one-cycle pulse on accepted 0->1 change.
- fall_pulse  output  N_CH  one-cycle pulse on accepted 1->0 change.

Behaviour:
- Reset (rstn=0 at posedge clk):
  - Clears both synchronizer flops, every channel FSM (->IDLE_LO), counters, level_out, rise_pulse and fall_pulse to 0.
  - Outputs stay 0 throughout reset.
  - Reset mid-operation aborts any pending acceptance.
- Synchronizer: two flops per channel, btn_in -> s1 -> s. Only s is used downstream.
- Per-channel FSM, 4 states; cnt is CNT_W bits:
  - IDLE_LO: level=0. If s=1: cnt<=1; if DEBOUNCE_CYCLES==1 go directly to IDLE_HI with rise, else go to ARM_HI.
  - ARM_HI: if s=0 go to IDLE_LO, cnt<=0, no pulse. Else if cnt==DEBOUNCE_CYCLES-1 go to IDLE_HI, level<=1, rise_pulse<=1. Else cnt<=cnt+1.
  - IDLE_HI: level=1. Mirror of IDLE_LO on s=0, going to ARM_LO, or directly to IDLE_LO with fall when DEBOUNCE_CYCLES==1.
  - ARM_LO: mirror of ARM_HI. s=1 returns to IDLE_HI; on completion level<=0, fall_pulse<=1.
- Latency:
  - btn_in sampled high at edge N and held: level_out and rise_pulse are 1 after edge N+1+DEBOUNCE_CYCLES.
  - Falling edge has the same latency.
- Pulses:
  - rise_pulse/fall_pulse are high for exactly one cycle, coincident with the level_out transition.
  - Never both high on one channel in the same cycle.
- Glitch rejection: a synchronized excursion shorter than DEBOUNCE_CYCLES cycles produces no pulse and leaves level_out unchanged. The counter restarts from the next excursion.
- Counter never wraps: it is bounded by DEBOUNCE_CYCLES-1 and reset on every abort.
- Channels are fully independent; simultaneous acceptance on several channels is allowed and produces simultaneous pulses.
- Input held high through reset: treated as a new press after reset release. Rise pulse occurs at the normal latency counted from the first post-reset sample.
- No combinational path from btn_in to any output; all outputs are registered.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: rstn=0 for 3 cycles with btn_in=2'b11 -> all outputs 0 during reset. After release, level_out[1:0]=2'b11 and rise_pulse=2'b11 for one cycle, 5 cycles after the first post-reset sample edge.
- Clean press ch0: btn_in[0] 0->1 sampled at edge 10, held -> rise_pulse[0]=1 only after edge 15. level_out[0]=1 from edge 15 on. fall_pulse stays 0.
- Glitch ch1: btn_in[1] high for 3 cycles then low -> no rise_pulse[1], level_out[1] stays 0. A subsequent 4-cycle-stable high produces exactly one rise.
- Release bounce ch0 (level=1): btn_in[0] toggles low 2 cycles, high 1, low held -> single fall_pulse[0], 5 edges after the final low sample. No extra pulses.
- Simultaneous: both channels pressed on the same edge -> rise_pulse=2'b11 in the same cycle, each for one cycle.
- Reset mid-ARM: assert rstn=0 while ch0 cnt=2 -> after release FSM is in IDLE_LO, cnt=0, no stale pulse. Acceptance restarts from a full DEBOUNCE_CYCLES count.
